// File: rtl/sha256_compress_core_pkg.sv
// sha256_compress_core_pkg: state encoding, K table, IV and the SHA-256 bit functions
package sha256_compress_core_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction
endpackage

// File: rtl/sha256_compress_core_round.sv
// sha256_compress_core_round: one combinational SHA-256 round; cur/nxt = a..h (a in MSBs), k = K[t], w = W[t]
module sha256_compress_core_round
  import sha256_compress_core_pkg::*;
(
  input  logic [255:0] cur,
  input  logic [31:0]  k,
  input  logic [31:0]  w,
  output logic [255:0] nxt
);
  logic [0:7][31:0] s;
  logic [31:0] t1, t2;
  assign s = cur;
  assign t1 = s[7] + bsig1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
  assign t2 = bsig0(s[0]) + maj(s[0], s[1], s[2]);
  assign nxt = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
endmodule

// File: rtl/sha256_compress_core.sv
// sha256_compress_core: iterative SHA-256 compression; in_valid/in_ready/in_block/in_first accept a block, out_valid/out_ready/out_hash deliver the digest
module sha256_compress_core
  import sha256_compress_core_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash
);
  localparam int R = ROUNDS_PER_CYCLE;
  state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  logic [0:15][31:0] w;
  logic [0:7][31:0] v, h;
  logic [31:0] ext [0:15+R];
  logic [255:0] st [0:R];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign out_hash = h;
  assign cnt_nxt = cnt + 6'(R);
  assign st[0] = v;
  genvar i;
  for (i = 0; i < 16; i++) begin : g_win
    assign ext[i] = w[i];
  end
  for (i = 0; i < R; i++) begin : g_rnd
    assign ext[16+i] = ssig1(ext[14+i]) + ext[9+i] + ssig0(ext[1+i]) + ext[i];
    sha256_compress_core_round u_round (
      .cur(st[i]),
      .k  (K[cnt + 6'(i)]),
      .w  (ext[i]),
      .nxt(st[i+1])
    );
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (in_valid ? ROUND : IDLE) :
                state == ROUND ? (cnt_nxt == 6'd0 ? FINAL : ROUND) :
                state == FINAL ? DONE :
                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      h <= IV;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        w <= in_block;
        v <= in_first ? IV : h;
        cnt <= '0;
        if (in_first) h <= IV;
      end
      if (state == ROUND) begin
        v <= st[R];
        cnt <= cnt_nxt;
        for (int k = 0; k < 16; k++) w[k] <= ext[k+R];
      end
      if (state == FINAL) for (int k = 0; k < 8; k++) h[k] <= h[k] + v[k];
    end
  end
endmodule

// File: tb/tb_sha256_compress_core.sv
// tb_sha256_compress_core: directed-vector bench over ROUNDS_PER_CYCLE = 1, 2, 4, 8, 16
module tb_sha256_compress_core;
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] MB_H = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] MB1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] MB2 = {480'h0, 32'h000001c0};
  typedef struct {
    int d;
    logic [511:0] blk;
    logic first;
    logic chk;
    logic [255:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] in_valid = '0;
  logic [4:0] in_first = '0;
  logic [4:0] out_ready = '0;
  logic [4:0] in_ready, out_valid;
  logic [511:0] in_block [5];
  logic [255:0] out_hash [5];
  int total = 0;
  int bad = 0;
  vec_t tv [9];
  always #5 clk = ~clk;
  genvar g;
  for (g = 0; g < 5; g++) begin : g_dut
    sha256_compress_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_block (in_block[g]),
      .in_first (in_first[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_hash (out_hash[g])
    );
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic finish_block(input int d, input logic chk, input logic [255:0] exp);
    int lat;
    lat = 0;
    do begin
      step;
      lat++;
    end while (!out_valid[d] && lat < 200);
    check($sformatf("latency r%0d", 1 << d), 256'(lat), 256'(64 / (1 << d) + 1));
    if (chk) check($sformatf("digest r%0d", 1 << d), out_hash[d], exp);
    out_ready[d] = 1'b1;
    step;
    out_ready[d] = 1'b0;
    check($sformatf("out_valid_clear r%0d", 1 << d), 256'(out_valid[d]), 256'd0);
  endtask
  task automatic run_block(input int d, input logic [511:0] blk, input logic first, input logic chk, input logic [255:0] exp);
    check($sformatf("in_ready_idle r%0d", 1 << d), 256'(in_ready[d]), 256'd1);
    in_valid[d] = 1'b1;
    in_block[d] = blk;
    in_first[d] = first;
    step;
    in_valid[d] = 1'b0;
    in_block[d] = '0;
    finish_block(d, chk, exp);
  endtask
  initial begin
    for (int d = 0; d < 5; d++) in_block[d] = '0;
    tv[0] = '{0, ABC, 1'b1, 1'b1, ABC_H};
    tv[1] = '{2, EMPTY, 1'b1, 1'b1, EMPTY_H};
    tv[2] = '{1, ABC, 1'b1, 1'b1, ABC_H};
    tv[3] = '{3, ABC, 1'b1, 1'b1, ABC_H};
    tv[4] = '{4, ABC, 1'b1, 1'b1, ABC_H};
    tv[5] = '{0, MB1, 1'b1, 1'b0, '0};
    tv[6] = '{0, MB2, 1'b0, 1'b1, MB_H};
    tv[7] = '{4, MB1, 1'b1, 1'b0, '0};
    tv[8] = '{4, MB2, 1'b0, 1'b1, MB_H};
    step;
    step;
    rst = 1'b0;
    for (int d = 0; d < 5; d++) begin
      check($sformatf("rst in_ready r%0d", 1 << d), 256'(in_ready[d]), 256'd1);
      check($sformatf("rst out_valid r%0d", 1 << d), 256'(out_valid[d]), 256'd0);
      check($sformatf("rst out_hash r%0d", 1 << d), out_hash[d], IV);
    end
    for (int n = 0; n < 9; n++) run_block(tv[n].d, tv[n].blk, tv[n].first, tv[n].chk, tv[n].exp);
    in_valid[0] = 1'b1;
    in_block[0] = ABC;
    in_first[0] = 1'b1;
    step;
    in_valid[0] = 1'b0;
    for (int c = 0; c < 200 && !out_valid[0]; c++) step;
    in_valid[0] = 1'b1;
    in_block[0] = EMPTY;
    for (int c = 0; c < 10; c++) begin
      check("stall out_valid", 256'(out_valid[0]), 256'd1);
      check("stall out_hash", out_hash[0], ABC_H);
      check("stall in_ready", 256'(in_ready[0]), 256'd0);
      step;
    end
    out_ready[0] = 1'b1;
    step;
    out_ready[0] = 1'b0;
    check("post_hs in_ready", 256'(in_ready[0]), 256'd1);
    check("post_hs out_valid", 256'(out_valid[0]), 256'd0);
    check("post_hs out_hash", out_hash[0], ABC_H);
    step;
    in_valid[0] = 1'b0;
    check("held accept in_ready", 256'(in_ready[0]), 256'd0);
    finish_block(0, 1'b1, EMPTY_H);
    in_valid[0] = 1'b1;
    in_block[0] = ABC;
    in_first[0] = 1'b1;
    step;
    in_valid[0] = 1'b0;
    repeat (30) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort in_ready", 256'(in_ready[0]), 256'd1);
    check("abort out_valid", 256'(out_valid[0]), 256'd0);
    check("abort out_hash", out_hash[0], IV);
    check("abort other out_hash", out_hash[4], IV);
    run_block(0, ABC, 1'b0, 1'b1, ABC_H);
    run_block(3, EMPTY, 1'b0, 1'b1, EMPTY_H);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
